// File: rtl/vram_pkg.sv
// Shared types for the vector-RAM port arbiter: requester tags and clear-engine states.
package vram_pkg;

  localparam int unsigned STARVE_W = 4;

  typedef enum logic [1:0] {REQ_NONE, REQ_CPU, REQ_VG, REQ_CLR} req_tag_e;

  typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_e;

endpackage

// File: rtl/vram_clear_engine.sv
// Region-fill engine: walks ptr from base for len words, issuing one write request per cycle.
module vram_clear_engine
  import vram_pkg::*;
#(
  parameter int unsigned ADDR = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr_start,
  input  logic [ADDR-1:0] clr_base,
  input  logic [ADDR:0]   clr_len,
  input  logic            clr_gnt,
  output logic            clr_req,
  output logic [ADDR-1:0] clr_addr,
  output logic            clr_busy,
  output logic            clr_done
);

  localparam int unsigned CNT_W = ADDR + 1;

  clr_state_e         r_state;
  clr_state_e         w_state_nxt;
  logic [ADDR-1:0]    r_ptr;
  logic [ADDR-1:0]    w_ptr_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               r_busy;
  logic               r_done;

  // Next-state: start is only honoured from IDLE; ptr wraps naturally at 2**ADDR.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      CLR_IDLE: begin
        if (clr_start) begin
          w_ptr_nxt   = clr_base;
          w_cnt_nxt   = clr_len;
          w_state_nxt = (clr_len == '0) ? CLR_DONE : CLR_RUN;
        end
      end
      CLR_RUN: begin
        if (clr_gnt) begin
          w_ptr_nxt = r_ptr + ADDR'(1);
          w_cnt_nxt = r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = CLR_DONE;
          end
        end
      end
      CLR_DONE: begin
        w_state_nxt = CLR_IDLE;
      end
      default: begin
        w_state_nxt = CLR_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CLR_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == CLR_RUN);
      r_done  <= (w_state_nxt == CLR_DONE);
    end
  end

  assign clr_req  = r_busy;
  assign clr_busy = r_busy;
  assign clr_addr = r_ptr;
  assign clr_done = r_done;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port arbiter for the vector RAM: CPU, vector generator and clear engine share port A,
// with a starvation promotion for the VG and a tag pipeline routing registered read data back.
module vram_arbiter
  import vram_pkg::*;
#(
  parameter int unsigned    DATA       = 8,
  parameter int unsigned    ADDR       = 10,
  parameter int unsigned    STARVE_MAX = 4,
  parameter logic [DATA-1:0] CLR_VAL   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_req,
  input  logic            cpu_wr,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_din,
  output logic            cpu_gnt,
  output logic            cpu_rvalid,
  output logic [DATA-1:0] cpu_rdata,
  input  logic            vg_req,
  input  logic [ADDR-1:0] vg_addr,
  output logic            vg_gnt,
  output logic            vg_rvalid,
  output logic [DATA-1:0] vg_rdata,
  input  logic            clr_start,
  input  logic [ADDR-1:0] clr_base,
  input  logic [ADDR:0]   clr_len,
  output logic            clr_busy,
  output logic            clr_done,
  output logic            ram_wr,
  output logic [ADDR-1:0] ram_addr,
  output logic [DATA-1:0] ram_din,
  input  logic [DATA-1:0] ram_dout
);

  logic [STARVE_W-1:0] r_starve;
  req_tag_e            r_tag;
  req_tag_e            w_tag_nxt;
  logic [DATA-1:0]     r_cpu_hold;
  logic [DATA-1:0]     r_vg_hold;
  logic                w_vg_first;
  logic                w_clr_req;
  logic                w_clr_gnt;
  logic [ADDR-1:0]     w_clr_addr;

  vram_clear_engine #(
    .ADDR (ADDR)
  ) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_start (clr_start),
    .clr_base  (clr_base),
    .clr_len   (clr_len),
    .clr_gnt   (w_clr_gnt),
    .clr_req   (w_clr_req),
    .clr_addr  (w_clr_addr),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done)
  );

  assign w_vg_first = vg_req && (r_starve == STARVE_W'(STARVE_MAX));

  // One grant per cycle; a starved VG jumps ahead of the CPU for a single cycle.
  always_comb begin
    cpu_gnt   = 1'b0;
    vg_gnt    = 1'b0;
    w_clr_gnt = 1'b0;
    ram_wr    = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    w_tag_nxt = REQ_NONE;
    if (w_vg_first) begin
      vg_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (vg_req) begin
      vg_gnt = 1'b1;
    end else if (w_clr_req) begin
      w_clr_gnt = 1'b1;
    end
    if (cpu_gnt) begin
      ram_wr    = cpu_wr;
      ram_addr  = cpu_addr;
      ram_din   = cpu_wr ? cpu_din : '0;
      w_tag_nxt = cpu_wr ? REQ_NONE : REQ_CPU;
    end else if (vg_gnt) begin
      ram_addr  = vg_addr;
      w_tag_nxt = REQ_VG;
    end else if (w_clr_gnt) begin
      ram_wr    = 1'b1;
      ram_addr  = w_clr_addr;
      ram_din   = CLR_VAL;
      w_tag_nxt = REQ_CLR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (vg_req && !vg_gnt) begin
      if (r_starve != STARVE_W'(STARVE_MAX)) begin
        r_starve <= r_starve + STARVE_W'(1);
      end
    end else begin
      r_starve <= '0;
    end
  end

  // Tag follows the RAM's one-cycle read latency; hold regs keep the last word after rvalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag      <= REQ_NONE;
      r_cpu_hold <= '0;
      r_vg_hold  <= '0;
    end else begin
      r_tag <= w_tag_nxt;
      if (r_tag == REQ_CPU) begin
        r_cpu_hold <= ram_dout;
      end
      if (r_tag == REQ_VG) begin
        r_vg_hold <= ram_dout;
      end
    end
  end

  assign cpu_rvalid = (r_tag == REQ_CPU);
  assign vg_rvalid  = (r_tag == REQ_VG);
  assign cpu_rdata  = cpu_rvalid ? ram_dout : r_cpu_hold;
  assign vg_rdata   = vg_rvalid ? ram_dout : r_vg_hold;

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares one port of the vector-RAM dual-port block RAM between three requesters: CPU (read/write), vector generator (read-only), and a built-in clear engine that fills a region with a constant.
- Sits between the 6502 bus decode / vector generator and port A of the RAM.
- The RAM port has a registered read: data appears one cycle after the address.
- The arbiter issues one access per cycle and tags it, so read data is returned to the requester that issued it.

Parameters:
- DATA, 8, RAM word width.
- ADDR, 10, RAM address width; depth is 2**ADDR.
- STARVE_MAX, 4, consecutive vector-generator denials before it is promoted above the CPU for one cycle (1..15).
- CLR_VAL, 0, word written by the clear engine.

Ports:
- clk  in  1  single system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_req  in  1  CPU access request
- cpu_wr  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR  CPU address
- cpu_din  in  DATA  CPU write data
- cpu_gnt  out  1  CPU access issued this cycle
- cpu_rvalid  out  1  CPU read data valid
- cpu_rdata  out  DATA  CPU read data
- vg_req  in  1  vector-generator read request
- vg_addr  in  ADDR  vector-generator address
- vg_gnt  out  1  VG read issued this cycle
- vg_rvalid  out  1  VG read data valid
- vg_rdata  out  DATA  VG read data
- clr_start  in  1  one-cycle pulse that starts a clear
- clr_base  in  ADDR  first address to clear
- clr_len  in  ADDR+1  number of words to clear (0..2**ADDR)
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle completion pulse
- ram_wr  out  1  RAM write enable
- ram_addr  out  ADDR  RAM address
- ram_din  out  DATA  RAM write data
- ram_dout  in  DATA  RAM registered read data

Behaviour:
- Reset (async, rst_n=0):
  - Registered outputs are cleared: cpu_rvalid, vg_rvalid, clr_busy, clr_done = 0.
  - cpu_rdata and vg_rdata hold 0.
  - Internal state: starve counter = 0, clear FSM = IDLE, read tag = NONE.
- Grants and RAM drive are combinational from the requests and the registered state. All of gnt, ram_wr, ram_addr and ram_din are 0 when nothing is granted.
- Priority each cycle:
  - Normal order is CPU > VG > CLR.
  - If starve_cnt == STARVE_MAX and vg_req=1, the order is VG > CPU > CLR.
  - Exactly one requester is granted per cycle, or none.
- Requester holding:
  - A requester that is not granted keeps its req, addr and data stable until granted.
  - gnt is the handshake: the access completes in the grant cycle.
- Starve counter:
  - Increments (saturating at STARVE_MAX) on every cycle with vg_req=1 and vg_gnt=0.
  - Clears to 0 on vg_gnt=1 or when vg_req=0.
- Read return:
  - A CPU read granted in cycle N gives cpu_rvalid=1 in cycle N+1, with cpu_rdata = ram_dout.
  - A VG grant returns data the same way on vg_rvalid / vg_rdata.
  - rdata is registered from ram_dout on the rvalid cycle and holds until the next read.
  - CPU writes and clear writes never assert rvalid.
- Clear FSM, states IDLE → RUN → DONE → IDLE:
  - IDLE: on clr_start, latch ptr = clr_base and cnt = clr_len. Go to DONE if clr_len == 0, otherwise to RUN.
  - RUN: clr_busy=1. The clear engine requests every cycle. When it is granted it writes CLR_VAL at ptr, then ptr = ptr+1 (mod 2**ADDR, so it wraps past the top of RAM) and cnt = cnt-1. When cnt reaches 0 it goes to DONE.
  - DONE: clr_done=1 for exactly one cycle, clr_busy=0, then IDLE.
  - clr_start while in RUN or DONE is ignored.
- Simultaneous events:
  - A CPU write and the clear engine targeting the same address in one cycle: the CPU is granted and the clear engine stalls to the next cycle. The clear value therefore wins on that address, which is intended (software reissues its writes after clr_done).
- Reset during RUN aborts the clear with no clr_done pulse. A read that is in flight is dropped (no rvalid).

Decomposition:
- Package vram_pkg holds:
  - the requester tag enum {REQ_NONE, REQ_CPU, REQ_VG, REQ_CLR};
  - the clear-state enum {CLR_IDLE, CLR_RUN, CLR_DONE}.
- Sub-module vram_clear_engine holds the FSM, ptr and cnt. Its interface is clr_req / clr_gnt / clr_addr.
- The arbiter top holds the priority logic, starve counter and read-tag pipeline.

Test Plan:
- CPU write 0x5A to 0x010, then CPU read 0x010 → cpu_gnt same cycle both times; cpu_rvalid one cycle after the read grant with cpu_rdata=0x5A; vg_rvalid stays 0.
- cpu_req and vg_req held high continuously, STARVE_MAX=4 → VG granted on every 5th cycle, and each VG read returns correct data one cycle after its grant.
- Clear with clr_base=0x3FE, clr_len=4, no other traffic → writes to 0x3FE, 0x3FF, 0x000, 0x001 on four consecutive cycles; clr_done pulses once on the next cycle; clr_busy high for exactly 4 cycles.
- Clear with clr_len=0 → no RAM writes, clr_done one cycle after clr_start, clr_busy never high.
- Clear of 8 words with a CPU write every other cycle → the clear finishes in 16 cycles; a second clr_start mid-run is ignored; all 8 words read back as 0x00.
- rst_n asserted mid-clear with a VG read in flight → all outputs 0 immediately; no clr_done and no vg_rvalid after release.
